fpu_pin_sequencer: RTL and testbench



---
 rtl/fpu_pin_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_fpu_pin_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_pin_sequencer.sv
// Byte-serial pin front end for the FPU: assembles opcode + two operands, issues them, returns result + flags.
// Latency: 1 cycle from the 9th synchronized byte event to fpu_valid_o; FPU backpressure holds the request indefinitely.
module fpu_pin_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int OUT_HOLD    = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  pin_data_i,
  input  logic        pin_stb_i,
  input  logic        pin_sof_i,
  output logic [31:0] fpu_op_a_o,
  output logic [31:0] fpu_op_b_o,
  output logic [3:0]  fpu_opcode_o,
  output logic [2:0]  fpu_rmode_o,
  output logic        fpu_valid_o,
  input  logic        fpu_ready_i,
  input  logic [31:0] fpu_res_i,
  input  logic [4:0]  fpu_flags_i,
  input  logic        fpu_res_valid_i,
  output logic [7:0]  pin_data_o,
  output logic        pin_stb_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int HW = (OUT_HOLD < 2) ? 1 : $clog2(OUT_HOLD);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(OUT_HOLD - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_SEND} state_t;

  typedef struct packed {
    logic [31:0] op_b;
    logic [31:0] op_a;
    logic [2:0]  rmode;
    logic [3:0]  opcode;
  } req_t;

  typedef struct packed {
    logic [4:0]  flags;
    logic [31:0] res;
  } rsp_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] stb_sync, sof_sync;
  logic                   stb_prev;
  logic                   byte_evt, sof_evt;
  logic                   sof_accept, byte_store, busy_drop, tmo_abort;
  logic [3:0]             byte_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic                   tmo_hit;
  logic [2:0]             send_idx;
  logic [HW-1:0]          hold_cnt;
  logic                   low_phase;
  logic                   send_last;
  logic                   err_q;
  req_t                   req_q;
  rsp_t                   rsp_q;

  // Strobe and SOF share the same depth so SOF lines up with its byte event.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stb_sync <= '0;
      sof_sync <= '0;
      stb_prev <= 1'b0;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], pin_stb_i};
      sof_sync <= {sof_sync[SYNC_STAGES-2:0], pin_sof_i};
      stb_prev <= stb_sync[SYNC_STAGES-1];
    end
  end

  assign byte_evt  = stb_sync[SYNC_STAGES-1] & ~stb_prev;
  assign sof_evt   = sof_sync[SYNC_STAGES-1];
  assign tmo_hit   = (tmo_cnt == TMO_MAX);
  assign send_last = low_phase && (hold_cnt == HOLD_LAST) && (send_idx == 3'd4);

  assign sof_accept = byte_evt && sof_evt && ((state_q == S_IDLE) || (state_q == S_LOAD));
  assign byte_store = byte_evt && !sof_evt && (state_q == S_LOAD);
  assign busy_drop  = byte_evt && ((state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_SEND));
  assign tmo_abort  = ((state_q == S_LOAD) && !byte_evt && tmo_hit) ||
                      ((state_q == S_WAIT) && !fpu_res_valid_i && tmo_hit);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (byte_evt && sof_evt) state_d = S_LOAD;
      S_LOAD: begin
        if (byte_evt) begin
          if (!sof_evt && byte_cnt == 4'd8) state_d = S_ISSUE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: if (fpu_ready_i) state_d = S_WAIT;
      S_WAIT: begin
        if (fpu_res_valid_i) state_d = S_SEND;
        else if (tmo_hit)    state_d = S_IDLE;
      end
      S_SEND:  if (send_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Idle-gap / result-wait counter restarts on every state change and every LOAD byte.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt <= '0;
    end else if ((state_q != state_d) || ((state_q == S_LOAD) && byte_evt)) begin
      tmo_cnt <= '0;
    end else if (((state_q == S_LOAD) || (state_q == S_WAIT)) && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else if (sof_accept) begin
      err_q <= 1'b0;
    end else if (busy_drop || tmo_abort) begin
      err_q <= 1'b1;
    end
  end

  // Bytes land straight in the request register; a restart overwrites every field before issue.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      req_q    <= '0;
      byte_cnt <= '0;
    end else if (sof_accept) begin
      req_q.opcode <= pin_data_i[3:0];
      req_q.rmode  <= pin_data_i[6:4];
      byte_cnt     <= 4'd1;
    end else if (byte_store) begin
      case (byte_cnt)
        4'd1:    req_q.op_a[7:0]   <= pin_data_i;
        4'd2:    req_q.op_a[15:8]  <= pin_data_i;
        4'd3:    req_q.op_a[23:16] <= pin_data_i;
        4'd4:    req_q.op_a[31:24] <= pin_data_i;
        4'd5:    req_q.op_b[7:0]   <= pin_data_i;
        4'd6:    req_q.op_b[15:8]  <= pin_data_i;
        4'd7:    req_q.op_b[23:16] <= pin_data_i;
        4'd8:    req_q.op_b[31:24] <= pin_data_i;
        default: ;
      endcase
      byte_cnt <= byte_cnt + 4'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp_q <= '0;
    end else if ((state_q == S_WAIT) && fpu_res_valid_i) begin
      rsp_q <= {fpu_flags_i, fpu_res_i};
    end
  end

  // Each returned byte: OUT_HOLD cycles strobe high, then OUT_HOLD cycles low.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      send_idx  <= '0;
      hold_cnt  <= '0;
      low_phase <= 1'b0;
    end else if (state_q != S_SEND) begin
      send_idx  <= '0;
      hold_cnt  <= '0;
      low_phase <= 1'b0;
    end else if (hold_cnt == HOLD_LAST) begin
      hold_cnt  <= '0;
      low_phase <= ~low_phase;
      if (low_phase) send_idx <= send_idx + 3'd1;
    end else begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  always_comb begin
    fpu_valid_o = (state_q == S_ISSUE);
    busy_o      = (state_q != S_IDLE);
    pin_stb_o   = (state_q == S_SEND) && !low_phase;
    pin_data_o  = 8'h00;
    if (state_q == S_SEND) begin
      case (send_idx)
        3'd0:    pin_data_o = rsp_q.res[7:0];
        3'd1:    pin_data_o = rsp_q.res[15:8];
        3'd2:    pin_data_o = rsp_q.res[23:16];
        3'd3:    pin_data_o = rsp_q.res[31:24];
        3'd4:    pin_data_o = {3'b000, rsp_q.flags};
        default: pin_data_o = 8'h00;
      endcase
    end
  end

  assign fpu_op_a_o   = req_q.op_a;
  assign fpu_op_b_o   = req_q.op_b;
  assign fpu_opcode_o = req_q.opcode;
  assign fpu_rmode_o  = req_q.rmode;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fpu_pin_sequencer.sv
// Directed bench for fpu_pin_sequencer: frame table plus timeout, restart, busy-byte and reset sequences.
module tb_fpu_pin_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [7:0]  pin_data_i;
  logic        pin_stb_i;
  logic        pin_sof_i;
  logic [31:0] fpu_op_a_o, fpu_op_b_o;
  logic [3:0]  fpu_opcode_o;
  logic [2:0]  fpu_rmode_o;
  logic        fpu_valid_o;
  logic        fpu_ready_i;
  logic [31:0] fpu_res_i;
  logic [4:0]  fpu_flags_i;
  logic        fpu_res_valid_i;
  logic [7:0]  pin_data_o;
  logic        pin_stb_o;
  logic        busy_o;
  logic        err_o;

  fpu_pin_sequencer dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .pin_data_i(pin_data_i), .pin_stb_i(pin_stb_i), .pin_sof_i(pin_sof_i),
    .fpu_op_a_o(fpu_op_a_o), .fpu_op_b_o(fpu_op_b_o),
    .fpu_opcode_o(fpu_opcode_o), .fpu_rmode_o(fpu_rmode_o),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
    .fpu_res_i(fpu_res_i), .fpu_flags_i(fpu_flags_i), .fpu_res_valid_i(fpu_res_valid_i),
    .pin_data_o(pin_data_o), .pin_stb_o(pin_stb_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  typedef struct packed {
    logic [71:0] frame;      // byte i at [8i +: 8]
    logic [31:0] res;
    logic [4:0]  flags;
    logic [3:0]  ready_dly;
    logic [3:0]  exp_opc;
    logic [2:0]  exp_rm;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [39:0] exp_out;    // returned byte k at [8k +: 8]
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int failures = 0;

  // FPU model state
  int          fpu_dly = 0;
  int          fpu_rdly = 3;
  bit          fpu_respond = 1'b1;
  logic [31:0] fpu_res_val = '0;
  logic [4:0]  fpu_flg_val = '0;
  int          vcnt = 0, last_vcnt = 0, issued = 0, rcnt = 0, first_valid_cyc = 0;
  logic [31:0] snap_a, snap_b;
  logic [3:0]  snap_opc;
  logic [2:0]  snap_rm;
  bit          stable = 1'b1;

  // Outbound collector state
  logic [7:0]  out_q[$];
  logic [7:0]  cur_byte = '0;
  bit          prev_stb = 1'b0, in_send = 1'b0, tim_bad = 1'b0, dat_bad = 1'b0;
  int          hi_run = 0, lo_run = 0;
  int          last_stb_cyc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  initial begin : fpu_model
    fpu_ready_i = 1'b0;
    fpu_res_valid_i = 1'b0;
    fpu_res_i = '0;
    fpu_flags_i = '0;
    forever begin
      @(negedge wb_clk_i);
      fpu_res_valid_i = 1'b0;
      if (fpu_valid_o) begin
        if (vcnt == 0) begin
          snap_a = fpu_op_a_o; snap_b = fpu_op_b_o;
          snap_opc = fpu_opcode_o; snap_rm = fpu_rmode_o;
          stable = 1'b1; first_valid_cyc = cyc;
        end else if (fpu_op_a_o !== snap_a || fpu_op_b_o !== snap_b ||
                     fpu_opcode_o !== snap_opc || fpu_rmode_o !== snap_rm) begin
          stable = 1'b0;
        end
        vcnt++;
        fpu_ready_i = (vcnt > fpu_dly);
      end else begin
        fpu_ready_i = 1'b0;
        if (vcnt != 0) begin
          last_vcnt = vcnt; vcnt = 0; issued++; rcnt = fpu_rdly;
        end else if (rcnt != 0) begin
          rcnt--;
          if (rcnt == 0 && fpu_respond) begin
            fpu_res_i = fpu_res_val; fpu_flags_i = fpu_flg_val; fpu_res_valid_i = 1'b1;
          end
        end
      end
    end
  end

  initial begin : collector
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        in_send = 1'b0; prev_stb = 1'b0;
      end else begin
        if (pin_stb_o) begin
          if (!prev_stb) begin
            if (in_send && lo_run != 4) tim_bad = 1'b1;
            out_q.push_back(pin_data_o);
            cur_byte = pin_data_o; hi_run = 1; in_send = 1'b1;
          end else begin
            hi_run++;
          end
          if (pin_data_o !== cur_byte) dat_bad = 1'b1;
        end else if (in_send) begin
          if (prev_stb) begin
            if (hi_run != 4) tim_bad = 1'b1;
            lo_run = 0;
          end
          if (busy_o) begin
            lo_run++;
            if (pin_data_o !== cur_byte) dat_bad = 1'b1;
          end else begin
            if (lo_run != 4) tim_bad = 1'b1;
            in_send = 1'b0;
          end
        end
        prev_stb = pin_stb_o;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic sof);
    @(negedge wb_clk_i);
    pin_data_i = d; pin_sof_i = sof;
    @(negedge wb_clk_i);
    pin_stb_i = 1'b1; last_stb_cyc = cyc;
    repeat (4) @(negedge wb_clk_i);
    pin_stb_i = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    pin_sof_i = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] fr);
    for (int i = 0; i < 9; i++) send_byte(fr[8*i +: 8], (i == 0));
  endtask

  task automatic run_vec(input vec_t v, input logic exp_err, input string tag);
    int  n0, stb9;
    bit  done;
    fpu_dly = int'(v.ready_dly); fpu_res_val = v.res; fpu_flg_val = v.flags;
    n0 = issued; out_q.delete(); tim_bad = 1'b0; dat_bad = 1'b0;
    send_frame(v.frame);
    stb9 = last_stb_cyc;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge wb_clk_i);
      if (out_q.size() >= 5 && !busy_o) done = 1'b1;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_issued"}, 64'(issued - n0), 64'd1);
    check({tag, "_valid_cycles"}, 64'(last_vcnt), 64'(int'(v.ready_dly) + 1));
    check({tag, "_issue_latency"}, 64'(first_valid_cyc - stb9), 64'd3);
    check({tag, "_opcode"}, 64'(snap_opc), 64'(v.exp_opc));
    check({tag, "_rmode"}, 64'(snap_rm), 64'(v.exp_rm));
    check({tag, "_op_a"}, 64'(snap_a), 64'(v.exp_a));
    check({tag, "_op_b"}, 64'(snap_b), 64'(v.exp_b));
    check({tag, "_req_stable"}, 64'(stable), 64'd1);
    check({tag, "_out_count"}, 64'(out_q.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] got;
      got = (k < out_q.size()) ? out_q[k] : 8'hxx;
      check($sformatf("%s_out_byte%0d", tag, k), 64'(got), 64'(v.exp_out[8*k +: 8]));
    end
    check({tag, "_strobe_timing_bad"}, 64'(tim_bad), 64'd0);
    check({tag, "_data_unstable"}, 64'(dat_bad), 64'd0);
    check({tag, "_err"}, 64'(err_o), 64'(exp_err));
    check({tag, "_data_idle"}, 64'(pin_data_o), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int  n0;
    bit  ok;
    vecs[0] = '{frame: {8'h40,8'h00,8'h00,8'h00,8'h3F,8'h80,8'h00,8'h00,8'h12},
                res: 32'h40400000, flags: 5'h00, ready_dly: 4'd0,
                exp_opc: 4'h2, exp_rm: 3'h1, exp_a: 32'h3F800000, exp_b: 32'h40000000,
                exp_out: {8'h00,8'h40,8'h40,8'h00,8'h00}};
    vecs[1] = '{frame: {8'h3F,8'h00,8'h00,8'h00,8'hC0,8'h00,8'h00,8'h00,8'h01},
                res: 32'hBF000000, flags: 5'h01, ready_dly: 4'd0,
                exp_opc: 4'h1, exp_rm: 3'h0, exp_a: 32'hC0000000, exp_b: 32'h3F000000,
                exp_out: {8'h01,8'hBF,8'h00,8'h00,8'h00}};
    vecs[2] = '{frame: {8'h9A,8'hBC,8'hDE,8'hF0,8'h12,8'h34,8'h56,8'h78,8'hF5},
                res: 32'hDEADBEEF, flags: 5'h1F, ready_dly: 4'd10,
                exp_opc: 4'h5, exp_rm: 3'h7, exp_a: 32'h12345678, exp_b: 32'h9ABCDEF0,
                exp_out: {8'h1F,8'hDE,8'hAD,8'hBE,8'hEF}};
    vecs[3] = '{frame: {8'h00,8'h00,8'h00,8'h00,8'hFF,8'hFF,8'hFF,8'hFF,8'h83},
                res: 32'h00000001, flags: 5'h10, ready_dly: 4'd3,
                exp_opc: 4'h3, exp_rm: 3'h0, exp_a: 32'hFFFFFFFF, exp_b: 32'h00000000,
                exp_out: {8'h10,8'h00,8'h00,8'h00,8'h01}};

    wb_rst_i = 1'b1; pin_data_i = '0; pin_stb_i = 1'b0; pin_sof_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("rst_valid", 64'(fpu_valid_o), 64'd0);
    check("rst_stb", 64'(pin_stb_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_req", 64'({fpu_op_a_o, fpu_opcode_o, fpu_rmode_o, pin_data_o}), 64'd0);
    check("rst_op_b", 64'(fpu_op_b_o), 64'd0);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // LOAD timeout, then recovery
    n0 = issued;
    send_byte(8'h12, 1'b1);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h80, 1'b0);
    repeat (100) @(negedge wb_clk_i);
    check("ldtmo_busy_mid", 64'(busy_o), 64'd1);
    check("ldtmo_err_mid", 64'(err_o), 64'd0);
    repeat (200) @(negedge wb_clk_i);
    check("ldtmo_busy", 64'(busy_o), 64'd0);
    check("ldtmo_err", 64'(err_o), 64'd1);
    check("ldtmo_no_issue", 64'(issued - n0), 64'd0);
    send_byte(8'h12, 1'b1);
    check("ldtmo_err_cleared", 64'(err_o), 64'd0);
    check("ldtmo_sof_busy", 64'(busy_o), 64'd1);
    run_vec(vecs[0], 1'b0, "ldtmo_recover");

    // Mid-frame restart
    send_byte(8'h77, 1'b1);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0); send_byte(8'h55, 1'b0);
    run_vec(vecs[1], 1'b0, "restart");

    // Stray byte in IDLE, then bytes during WAIT and SEND
    send_byte(8'h55, 1'b0);
    repeat (2) @(negedge wb_clk_i);
    check("idle_stray_err", 64'(err_o), 64'd0);
    check("idle_stray_busy", 64'(busy_o), 64'd0);
    fpu_rdly = 20;
    fork
      run_vec(vecs[3], 1'b1, "busybytes");
      begin
        int  m0;
        bit  seen;
        m0 = issued; seen = 1'b0;
        for (int t = 0; t < 2000 && !seen; t++) begin
          @(negedge wb_clk_i);
          if (issued > m0) seen = 1'b1;
        end
        check("busy_issue_seen", 64'(seen), 64'd1);
        check("busy_err_before", 64'(err_o), 64'd0);
        send_byte(8'hAA, 1'b0);
        check("busy_wait_byte_err", 64'(err_o), 64'd1);
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge wb_clk_i);
          if (pin_stb_o) seen = 1'b1;
        end
        check("busy_send_seen", 64'(seen), 64'd1);
        send_byte(8'hBB, 1'b1);
        check("busy_send_byte_busy", 64'(busy_o), 64'd1);
      end
    join
    fpu_rdly = 3;

    // WAIT timeout: FPU accepts but never answers
    fpu_respond = 1'b0; fpu_dly = 0; out_q.delete();
    n0 = issued;
    send_frame(vecs[0].frame);
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge wb_clk_i);
      if (issued > n0) ok = 1'b1;
    end
    check("wttmo_issued", 64'(ok), 64'd1);
    check("wttmo_err_cleared_by_sof", 64'(err_o), 64'd0);
    repeat (100) @(negedge wb_clk_i);
    check("wttmo_busy_mid", 64'(busy_o), 64'd1);
    repeat (200) @(negedge wb_clk_i);
    check("wttmo_busy", 64'(busy_o), 64'd0);
    check("wttmo_err", 64'(err_o), 64'd1);
    check("wttmo_no_output", 64'(out_q.size()), 64'd0);
    fpu_respond = 1'b1;

    // Reset during byte 3 strobe-high phase
    fpu_dly = 0; fpu_res_val = vecs[0].res; fpu_flg_val = vecs[0].flags; out_q.delete();
    send_frame(vecs[0].frame);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge wb_clk_i);
      if (out_q.size() >= 3) ok = 1'b1;
    end
    check("rstsend_reached_byte3", 64'(ok), 64'd1);
    @(negedge wb_clk_i);
    check("rstsend_stb_before", 64'(pin_stb_o), 64'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    check("rstsend_stb_async", 64'(pin_stb_o), 64'd0);
    check("rstsend_busy_async", 64'(busy_o), 64'd0);
    check("rstsend_data_async", 64'(pin_data_o), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    run_vec(vecs[2], 1'b0, "rstsend_recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
